// File: rtl/icache_mem_arbiter.sv
// Shares one word-wide memory port between icache refills and the data-side requester.
// Round-robin grant, one transaction in flight, per-transaction timeout with a sticky bus_err.
//
// state | meaning
// IDLE  | no transaction; sample requests and grant round-robin
// ISSUE | mem_valid high with a frozen payload until mem_ready
// WAIT  | waiting for mem_rvalid (read data or write acknowledge)
// RESP  | one-cycle ic_fetch or d_done pulse, then back to IDLE
module icache_mem_arbiter #(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ic_miss,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_fetch,
    output logic [DATA_W-1:0] ic_wdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state;
    logic              last_d;
    logic              owner_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        to_cnt;
    logic              grant_i;
    logic              grant_d;
    logic              timeout;
    logic              unused_addr_lsbs;

    // On a tie the requester that did not win last time gets the port.
    assign grant_i = ic_miss & (~d_req | last_d);
    assign grant_d = d_req & (~ic_miss | ~last_d);

    // Counter value this cycle is (cycles already spent in ISSUE/WAIT); this is the last allowed one.
    assign timeout = (to_cnt >= TO_LAST);

    assign unused_addr_lsbs = ^{ic_addr[1:0], d_addr[1:0]};

    assign mem_valid = (state == S_ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ic_fetch  = (state == S_RESP) & ~owner_d;
    assign d_done    = (state == S_RESP) & owner_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            last_d   <= 1'b1;
            owner_d  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            to_cnt   <= '0;
            ic_wdata <= '0;
            d_rdata  <= '0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_i || grant_d) begin
                        owner_d <= grant_d;
                        last_d  <= grant_d;
                        we_q    <= grant_d & d_we;
                        addr_q  <= grant_d ? {d_addr[ADDR_W-1:2], 2'b00}
                                           : {ic_addr[ADDR_W-1:2], 2'b00};
                        wdata_q <= grant_d ? d_wdata : '0;
                        to_cnt  <= '0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    to_cnt <= to_cnt + 8'd1;
                    if (mem_ready) begin
                        state <= S_WAIT;
                    end else if (timeout) begin
                        if (owner_d) d_rdata <= '0;
                        else         ic_wdata <= '0;
                        bus_err <= 1'b1;
                        state   <= S_RESP;
                    end
                end
                S_WAIT: begin
                    to_cnt <= to_cnt + 8'd1;
                    // A response arriving on the timeout cycle still counts as good.
                    if (mem_rvalid) begin
                        if (owner_d) d_rdata <= we_q ? '0 : mem_rdata;
                        else         ic_wdata <= mem_rdata;
                        state <= S_RESP;
                    end else if (timeout) begin
                        if (owner_d) d_rdata <= '0;
                        else         ic_wdata <= '0;
                        bus_err <= 1'b1;
                        state   <= S_RESP;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Scoreboard bench for icache_mem_arbiter: directed scenarios plus an automatic memory responder.
module tb_icache_mem_arbiter;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } resp_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ic_miss = 1'b0;
    logic [19:0] ic_addr = '0;
    logic        ic_fetch;
    logic [31:0] ic_wdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [19:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        bus_err;

    int    n_cmp = 0;
    int    n_bad = 0;
    resp_t sb[$];
    resp_t ev[$];
    int    rv_cnt = 0;
    logic [31:0] rv_data = '0;

    icache_mem_arbiter #(.ADDR_W(20), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ic_miss(ic_miss), .ic_addr(ic_addr), .ic_fetch(ic_fetch), .ic_wdata(ic_wdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    // Responder returns {12'hA5A, word address} for reads.
    function automatic logic [31:0] exp_read(input logic [19:0] a);
        return {12'hA5A, a[19:2], 2'b00};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic auto_cycle();
        mem_ready = 1'b1;
        if (rv_cnt == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rv_data;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        if (mem_valid) begin
            rv_cnt  = 2;
            rv_data = {12'hA5A, mem_addr};
        end else if (rv_cnt > 0) begin
            rv_cnt--;
        end
        tick();
        if (ic_fetch) begin
            ev.push_back({1'b0, ic_wdata});
            ic_miss = 1'b0;
        end
        if (d_done) begin
            ev.push_back({1'b1, d_rdata});
            d_req = 1'b0;
        end
    endtask

    task automatic run_until(input int n, input int budget, output bit expired);
        rv_cnt = 0;
        for (int i = 0; i < budget && ev.size() < n; i++) auto_cycle();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        expired = (ev.size() < n);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({mem_valid, ic_fetch, d_done, bus_err, mem_we} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 00000", {mem_valid, ic_fetch, d_done, bus_err, mem_we});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, ic_wdata, d_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got addr %h wdata %h ic %h d %h expected all 0",
                     mem_addr, mem_wdata, ic_wdata, d_rdata);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_tie();
        bit    exp_out;
        resp_t e, g;
        ic_miss = 1'b1; ic_addr = 20'h00200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00400;
        sb.push_back({1'b0, exp_read(20'h00200)});
        sb.push_back({1'b1, exp_read(20'h00400)});
        run_until(2, 60, exp_out);
        n_cmp++;
        if (exp_out) begin n_bad++; $display("FAIL tie1_timeout: got %0d responses expected 2", ev.size()); end
        tick();
        ic_miss = 1'b1; ic_addr = 20'h00300;
        sb.push_back({1'b0, exp_read(20'h00300)});
        run_until(3, 40, exp_out);
        tick();
        ic_miss = 1'b1; ic_addr = 20'h00310;
        d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00404;
        sb.push_back({1'b1, exp_read(20'h00404)});
        sb.push_back({1'b0, exp_read(20'h00310)});
        run_until(5, 60, exp_out);
        n_cmp++;
        if (exp_out) begin n_bad++; $display("FAIL tie2_timeout: got %0d responses expected 5", ev.size()); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (ev.size() == 0) begin
                n_bad++;
                $display("FAIL tie_order: got no response expected owner %b data %h", e.is_d, e.data);
            end else begin
                g = ev.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL tie_order: got owner %b data %h expected owner %b data %h",
                             g.is_d, g.data, e.is_d, e.data);
                end
            end
        end
        tick();
    endtask

    task automatic test_icache_miss();
        resp_t e;
        tick(); tick();
        ic_miss = 1'b1; ic_addr = 20'h00123; mem_ready = 1'b1; mem_rvalid = 1'b0;
        sb.push_back({1'b0, 32'h00B70000});
        n_cmp++;
        if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL miss_pre_valid: got %b expected 0", mem_valid); end
        tick();
        n_cmp++;
        if ({mem_valid, mem_we, mem_addr} !== {1'b1, 1'b0, 20'h00120}) begin
            n_bad++;
            $display("FAIL miss_issue: got valid %b we %b addr %h expected 1 0 00120", mem_valid, mem_we, mem_addr);
        end
        tick();
        mem_ready = 1'b0;
        n_cmp++;
        if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL miss_wait_valid: got %b expected 0", mem_valid); end
        tick(); tick();
        n_cmp++;
        if (ic_fetch !== 1'b0) begin n_bad++; $display("FAIL miss_early_fetch: got %b expected 0", ic_fetch); end
        mem_rvalid = 1'b1; mem_rdata = 32'h00B70000;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        e = sb.pop_front();
        n_cmp++;
        if ({ic_fetch, d_done, ic_wdata} !== {1'b1, 1'b0, e.data}) begin
            n_bad++;
            $display("FAIL miss_fetch: got fetch %b done %b data %h expected 1 0 %h", ic_fetch, d_done, ic_wdata, e.data);
        end
        ic_miss = 1'b0;
        tick();
        n_cmp++;
        if ({ic_fetch, ic_wdata} !== {1'b0, 32'h00B70000}) begin
            n_bad++;
            $display("FAIL miss_hold: got fetch %b data %h expected 0 00b70000", ic_fetch, ic_wdata);
        end
    endtask

    task automatic test_data_write();
        resp_t e;
        tick(); tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 20'h00804; d_wdata = 32'hDEADBEEF; mem_ready = 1'b0;
        sb.push_back({1'b1, 32'h0});
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if ({mem_valid, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 20'h00804, 32'hDEADBEEF}) begin
                n_bad++;
                $display("FAIL write_stable[%0d]: got valid %b we %b addr %h wdata %h expected 1 1 00804 deadbeef",
                         k, mem_valid, mem_we, mem_addr, mem_wdata);
            end
            if (k == 4) mem_ready = 1'b1;
        end
        tick();
        mem_ready = 1'b0;
        n_cmp++;
        if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL write_wait_valid: got %b expected 0", mem_valid); end
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        e = sb.pop_front();
        n_cmp++;
        if ({d_done, ic_fetch, d_rdata} !== {1'b1, 1'b0, e.data}) begin
            n_bad++;
            $display("FAIL write_done: got done %b fetch %b rdata %h expected 1 0 %h", d_done, ic_fetch, d_rdata, e.data);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int    n;
        bit    exp_out;
        resp_t e, g;
        tick(); tick();
        ic_miss = 1'b1; ic_addr = 20'h00040; mem_ready = 1'b0; mem_rvalid = 1'b0;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n = 2;
        while (!ic_fetch && n < 30) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n !== 9) begin n_bad++; $display("FAIL timeout_latency: got %0d edges expected 9", n); end
        n_cmp++;
        if ({ic_fetch, ic_wdata, bus_err} !== {1'b1, 32'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL timeout_resp: got fetch %b data %h err %b expected 1 00000000 1", ic_fetch, ic_wdata, bus_err);
        end
        ic_miss = 1'b0;
        tick(); tick();
        ic_miss = 1'b1; ic_addr = 20'h00044;
        sb.push_back({1'b0, exp_read(20'h00044)});
        run_until(1, 40, exp_out);
        e = sb.pop_front();
        g = (ev.size() > 0) ? ev.pop_front() : '0;
        n_cmp++;
        if (exp_out || g !== e) begin
            n_bad++;
            $display("FAIL timeout_next: got owner %b data %h expected owner %b data %h", g.is_d, g.data, e.is_d, e.data);
        end
        tick();
        n_cmp++;
        if (bus_err !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b expected 1", bus_err); end
    endtask

    task automatic test_reset_mid_wait();
        bit    seen;
        bit    exp_out;
        resp_t e, g;
        tick(); tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00100; mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        n_cmp++;
        if ({mem_valid, bus_err} !== 2'b01) begin
            n_bad++;
            $display("FAIL rst_pre: got valid %b err %b expected 0 1", mem_valid, bus_err);
        end
        RST_N = 1'b0; d_req = 1'b0;
        tick();
        RST_N = 1'b1;
        n_cmp++;
        if ({mem_valid, bus_err, d_rdata, ic_wdata} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: got valid %b err %b d %h ic %h expected all 0", mem_valid, bus_err, d_rdata, ic_wdata);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (ic_fetch || d_done || mem_valid) seen = 1'b1;
            tick();
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_late_rvalid: got activity 1 expected 0"); end
        d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00108;
        sb.push_back({1'b1, exp_read(20'h00108)});
        run_until(1, 40, exp_out);
        e = sb.pop_front();
        g = (ev.size() > 0) ? ev.pop_front() : '0;
        n_cmp++;
        if (exp_out || g !== e) begin
            n_bad++;
            $display("FAIL rst_recover: got owner %b data %h expected owner %b data %h", g.is_d, g.data, e.is_d, e.data);
        end
        tick();
    endtask

    task automatic test_timeout_race();
        tick(); tick();
        ic_miss = 1'b1; ic_addr = 20'h00080; mem_ready = 1'b0;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if ({ic_fetch, mem_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL race_pre: got fetch %b valid %b expected 0 0", ic_fetch, mem_valid);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        n_cmp++;
        if ({ic_fetch, ic_wdata, bus_err} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin
            n_bad++;
            $display("FAIL race_resp: got fetch %b data %h err %b expected 1 cafef00d 0", ic_fetch, ic_wdata, bus_err);
        end
        ic_miss = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit    bad_resp_valid;
        resp_t e, g;
        tick(); tick();
        rv_cnt = 0;
        bad_resp_valid = 1'b0;
        ic_miss = 1'b1; ic_addr = 20'h00500;
        sb.push_back({1'b0, exp_read(20'h00500)});
        for (int k = 0; k < 30 && ev.size() < 1; k++) begin
            auto_cycle();
            if (ic_fetch && mem_valid) bad_resp_valid = 1'b1;
        end
        auto_cycle();
        n_cmp++;
        if (ic_fetch !== 1'b0) begin n_bad++; $display("FAIL b2b_pulse_width: got %b expected 0", ic_fetch); end
        auto_cycle();
        ic_miss = 1'b1; ic_addr = 20'h00504;
        sb.push_back({1'b0, exp_read(20'h00504)});
        auto_cycle();
        n_cmp++;
        if ({mem_valid, mem_addr} !== {1'b1, 20'h00504}) begin
            n_bad++;
            $display("FAIL b2b_reissue: got valid %b addr %h expected 1 00504", mem_valid, mem_addr);
        end
        for (int k = 0; k < 30 && ev.size() < 2; k++) begin
            auto_cycle();
            if (ic_fetch && mem_valid) bad_resp_valid = 1'b1;
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        n_cmp++;
        if (bad_resp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_in_resp: got 1 expected 0"); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = (ev.size() > 0) ? ev.pop_front() : '0;
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL b2b_data: got owner %b data %h expected owner %b data %h", g.is_d, g.data, e.is_d, e.data);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_icache_miss();
        test_data_write();
        test_timeout();
        test_reset_mid_wait();
        test_timeout_race();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
